dino_input_cond: RTL and testbench

DINO_INPUT_COND -- requirements
Module: dino_input_cond

---
 rtl/dino_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 44 ++++
 rtl/dino_input_cond.sv | 106 ++++++++++
 tb/tb_dino_input_cond.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared constants and types for the dino input conditioning block.
// Pad bit map, config word type and power-on config defaults.
package dino_pkg;

    typedef logic [3:0] cfg_t;

    localparam cfg_t CFG_DEF_ACCEL = 4'd4;
    localparam cfg_t CFG_DEF_SPEED = 4'd2;

    localparam int PAD_W        = 12;
    localparam int PAD_JUMP     = 0;
    localparam int PAD_HALT     = 1;
    localparam int PAD_DEBUG    = 2;
    localparam int PAD_SPEED_LO = 3;
    localparam int PAD_SPEED_HI = 6;
    localparam int PAD_ACCEL_LO = 7;
    localparam int PAD_ACCEL_HI = 10;
    localparam int PAD_OVR      = 11;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stability counter, accepted level.
// Ports: clock, reset (async low), pad (raw), level (debounced), rise (1-cycle).
module btn_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic pad,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          differ;
    logic          done;

    assign differ = sync_q[1] ^ level;
    // Accept on the cycle the counter already sits at its last value,
    // so the counter never needs to hold DB_CYCLES itself.
    assign done   = differ && (cnt_q == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pad};
            rise   <= done & sync_q[1];
            if (!differ || done)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            if (done)
                level <= sync_q[1];
        end
    end

endmodule

// File: rtl/dino_input_cond.sv
// Conditions raw game pads: debounced buttons plus frame-latched config.
// Ports: clock, reset (async low), pad_in[11:0], vsync -> jump_out,
// jump_pulse, halt_out, debug_out, cfg_accel, cfg_speed.
// Macro DINO_HALT_TOGGLE_EN: halt_out becomes a pause latch toggled by
// each halt press instead of following the debounced halt level.
module dino_input_cond
    import dino_pkg::*;
#(
    parameter int   DB_CYCLES = 250000,
    parameter cfg_t DEF_ACCEL = CFG_DEF_ACCEL,
    parameter cfg_t DEF_SPEED = CFG_DEF_SPEED
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PAD_W-1:0] pad_in,
    input  logic             vsync,
    output logic             jump_out,
    output logic             jump_pulse,
    output logic             halt_out,
    output logic             debug_out,
    output cfg_t             cfg_accel,
    output cfg_t             cfg_speed
);

    logic halt_lvl;
    logic halt_rise;
    logic debug_rise;
    logic unused_sig;

    logic [PAD_OVR:PAD_SPEED_LO] cs1_q;
    logic [PAD_OVR:PAD_SPEED_LO] cs2_q;
    logic                        vsync_q;
    logic                        frame_start;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_jump (
        .clock (clock),
        .reset (reset),
        .pad   (pad_in[PAD_JUMP]),
        .level (jump_out),
        .rise  (jump_pulse)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_halt (
        .clock (clock),
        .reset (reset),
        .pad   (pad_in[PAD_HALT]),
        .level (halt_lvl),
        .rise  (halt_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debug (
        .clock (clock),
        .reset (reset),
        .pad   (pad_in[PAD_DEBUG]),
        .level (debug_out),
        .rise  (debug_rise)
    );

    // Config pads only need synchronizing; they are sampled once per frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs1_q   <= '0;
            cs2_q   <= '0;
            vsync_q <= 1'b0;
        end else begin
            cs1_q   <= pad_in[PAD_OVR:PAD_SPEED_LO];
            cs2_q   <= cs1_q;
            vsync_q <= vsync;
        end
    end

    assign frame_start = vsync_q & ~vsync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_accel <= DEF_ACCEL;
            cfg_speed <= DEF_SPEED;
        end else if (frame_start) begin
            if (cs2_q[PAD_OVR]) begin
                cfg_accel <= cs2_q[PAD_ACCEL_HI:PAD_ACCEL_LO];
                cfg_speed <= cs2_q[PAD_SPEED_HI:PAD_SPEED_LO];
            end else begin
                cfg_accel <= DEF_ACCEL;
                cfg_speed <= DEF_SPEED;
            end
        end
    end

`ifdef DINO_HALT_TOGGLE_EN
    logic halt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            halt_q <= 1'b0;
        else if (halt_rise)
            halt_q <= ~halt_q;
    end

    assign halt_out   = halt_q;
    assign unused_sig = debug_rise ^ halt_lvl;
`else
    assign halt_out   = halt_lvl;
    assign unused_sig = debug_rise ^ halt_rise;
`endif

endmodule

// File: tb/tb_dino_input_cond.sv
// Randomized and directed bench for dino_input_cond with DB_CYCLES=8.
// Reference model: sliding window of synced samples per button.
module tb_dino_input_cond;

    localparam int DB = 8;

    logic        clock;
    logic        reset;
    logic [11:0] pad_in;
    logic        vsync;
    logic        jump_out;
    logic        jump_pulse;
    logic        halt_out;
    logic        debug_out;
    logic [3:0]  cfg_accel;
    logic [3:0]  cfg_speed;

    int vectors = 0;
    int errors  = 0;

    dino_input_cond #(
        .DB_CYCLES (DB),
        .DEF_ACCEL (4'd4),
        .DEF_SPEED (4'd2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pad_in     (pad_in),
        .vsync      (vsync),
        .jump_out   (jump_out),
        .jump_pulse (jump_pulse),
        .halt_out   (halt_out),
        .debug_out  (debug_out),
        .cfg_accel  (cfg_accel),
        .cfg_speed  (cfg_speed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [11:0] rawh0, rawh1;
    logic [11:0] win[$];
    logic [2:0]  m_acc;
    logic        m_pulse;
    logic        m_halt;
    logic        hr_pend;
    logic [3:0]  m_accel, m_speed;
    logic        m_vs;

    task automatic model_clear();
        rawh0   = '0;
        rawh1   = '0;
        win.delete();
        m_acc   = '0;
        m_pulse = 1'b0;
        m_halt  = 1'b0;
        hr_pend = 1'b0;
        m_accel = 4'd4;
        m_speed = 4'd2;
        m_vs    = 1'b0;
    endtask

    // Advance one clock; the model sees the inputs present at the edge.
    // A button flips once its last DB synced samples all disagree with it.
    task automatic step();
        logic [11:0] syn;
        logic        fs;
        logic        all_diff;
        @(posedge clock);
        if (reset) begin
            syn   = rawh1;
            fs    = m_vs & ~vsync;
            m_vs  = vsync;
            rawh1 = rawh0;
            rawh0 = pad_in;
            win.push_back(syn);
            if (win.size() > DB)
                void'(win.pop_front());
            if (hr_pend)
                m_halt = ~m_halt;
            hr_pend = 1'b0;
            m_pulse = 1'b0;
            for (int b = 0; b < 3; b++) begin
                if (win.size() == DB) begin
                    all_diff = 1'b1;
                    foreach (win[i])
                        if (win[i][b] == m_acc[b])
                            all_diff = 1'b0;
                    if (all_diff) begin
                        m_acc[b] = ~m_acc[b];
                        if (m_acc[b] && b == 0)
                            m_pulse = 1'b1;
                        if (m_acc[b] && b == 1)
                            hr_pend = 1'b1;
                    end
                end
            end
`ifndef DINO_HALT_TOGGLE_EN
            m_halt  = m_acc[1];
            hr_pend = 1'b0;
`endif
            if (fs) begin
                if (syn[11]) begin
                    m_accel = syn[10:7];
                    m_speed = syn[6:3];
                end else begin
                    m_accel = 4'd4;
                    m_speed = 4'd2;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] got, exp;
        // power-on reset, before any clock edge
        vectors++;
        got = {jump_out, jump_pulse, halt_out, debug_out, cfg_accel, cfg_speed};
        exp = {4'b0000, 4'd4, 4'd2};
        if (got !== exp) begin
            errors++;
            $display("FAIL por: got %h want %h", got, exp);
        end
        apply_reset();
        pad_in = {1'b1, 4'd9, 4'd5, 3'b001};
        vsync  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            got = {jump_out, jump_pulse, halt_out, debug_out, cfg_accel, cfg_speed};
            exp = {m_acc[0], m_pulse, m_halt, m_acc[2], m_accel, m_speed};
            if (got !== exp) begin
                errors++;
                $display("FAIL rst_pre cyc %0d: got %h want %h", i, got, exp);
            end
        end
        vsync = 1'b0;
        step();
        vectors++;
        got = {jump_out, jump_pulse, halt_out, debug_out, cfg_accel, cfg_speed};
        exp = {1'b1, 3'b000, 4'd9, 4'd5};
        if (got !== exp) begin
            errors++;
            $display("FAIL rst_setup: got %h want %h", got, exp);
        end
        // asynchronous assertion between edges
        #2 reset = 1'b0;
        #1;
        vectors++;
        got = {jump_out, jump_pulse, halt_out, debug_out, cfg_accel, cfg_speed};
        exp = {4'b0000, 4'd4, 4'd2};
        if (got !== exp) begin
            errors++;
            $display("FAIL rst_async: got %h want %h", got, exp);
        end
        model_clear();
        pad_in = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_jump_clean();
        logic [11:0] got, exp;
        int rise_at, pulses;
        rise_at = -1;
        pulses  = 0;
        apply_reset();
        pad_in[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (jump_out === 1'b1 && rise_at < 0)
                rise_at = i;
            if (jump_pulse === 1'b1)
                pulses++;
            vectors++;
            got = {jump_out, jump_pulse, halt_out, debug_out, cfg_accel, cfg_speed};
            exp = {m_acc[0], m_pulse, m_halt, m_acc[2], m_accel, m_speed};
            if (got !== exp) begin
                errors++;
                $display("FAIL jump cyc %0d: got %h want %h", i, got, exp);
            end
        end
        vectors++;
        if (rise_at !== 10) begin
            errors++;
            $display("FAIL jump_latency: got %0d want 10", rise_at);
        end
        vectors++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL jump_pulse_count: got %0d want 1", pulses);
        end
        pad_in[0] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (jump_pulse === 1'b1)
                pulses++;
        end
        vectors++;
        if (jump_out !== 1'b0 || pulses !== 0) begin
            errors++;
            $display("FAIL jump_fall: got lvl %b pulses %0d want 0 0",
                     jump_out, pulses);
        end
    endtask

    task automatic test_bounce();
        int seen;
        seen = 0;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0)
                pad_in[0] = ~pad_in[0];
            step();
            if (jump_out !== 1'b0 || jump_pulse !== 1'b0)
                seen++;
        end
        pad_in[0] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (jump_out !== 1'b0 || jump_pulse !== 1'b0)
                seen++;
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL bounce: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_halt();
        logic prev;
        int   trans, first_rise, cyc;
        trans      = 0;
        first_rise = -1;
        cyc        = 0;
        prev       = 1'b0;
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 26; i++) begin
                pad_in[1] = (i < 12);
                step();
                cyc++;
                if (halt_out !== prev) begin
                    trans++;
                    if (first_rise < 0)
                        first_rise = cyc;
                end
                prev = halt_out;
                vectors++;
                if (halt_out !== m_halt) begin
                    errors++;
                    $display("FAIL halt cyc %0d: got %b want %b",
                             cyc, halt_out, m_halt);
                end
            end
        end
`ifdef DINO_HALT_TOGGLE_EN
        vectors++;
        if (trans !== 2 || first_rise !== 11 || halt_out !== 1'b0) begin
            errors++;
            $display("FAIL halt_toggle: got %0d/%0d/%b want 2/11/0",
                     trans, first_rise, halt_out);
        end
`else
        vectors++;
        if (trans !== 4 || first_rise !== 10 || halt_out !== 1'b0) begin
            errors++;
            $display("FAIL halt_level: got %0d/%0d/%b want 4/10/0",
                     trans, first_rise, halt_out);
        end
`endif
    endtask

    task automatic test_cfg();
        apply_reset();
        pad_in = {1'b1, 4'd9, 4'd5, 3'b000};
        vsync  = 1'b1;
        for (int i = 0; i < 4; i++)
            step();
        vectors++;
        if (cfg_accel !== 4'd4 || cfg_speed !== 4'd2) begin
            errors++;
            $display("FAIL cfg_hold: got %0d/%0d want 4/2", cfg_accel, cfg_speed);
        end
        vsync = 1'b0;
        #2;
        vectors++;
        if (cfg_accel !== 4'd4 || cfg_speed !== 4'd2) begin
            errors++;
            $display("FAIL cfg_early: got %0d/%0d want 4/2", cfg_accel, cfg_speed);
        end
        step();
        vectors++;
        if (cfg_accel !== 4'd9 || cfg_speed !== 4'd5) begin
            errors++;
            $display("FAIL cfg_load: got %0d/%0d want 9/5", cfg_accel, cfg_speed);
        end
        pad_in[11] = 1'b0;
        pad_in[10:7] = 4'd1;
        for (int i = 0; i < 4; i++)
            step();
        vectors++;
        if (cfg_accel !== 4'd9 || cfg_speed !== 4'd5) begin
            errors++;
            $display("FAIL cfg_between: got %0d/%0d want 9/5", cfg_accel, cfg_speed);
        end
        vsync = 1'b1;
        step();
        step();
        vsync = 1'b0;
        step();
        vectors++;
        if (cfg_accel !== 4'd4 || cfg_speed !== 4'd2) begin
            errors++;
            $display("FAIL cfg_default: got %0d/%0d want 4/2", cfg_accel, cfg_speed);
        end
        pad_in = '0;
    endtask

    task automatic test_reset_midcount();
        int rise_at;
        rise_at = -1;
        apply_reset();
        pad_in[2] = 1'b1;
        for (int i = 0; i < 8; i++)
            step();
        vectors++;
        if (debug_out !== 1'b0) begin
            errors++;
            $display("FAIL dbg_pre: got %b want 0", debug_out);
        end
        #2 reset = 1'b0;
        model_clear();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (debug_out === 1'b1 && rise_at < 0)
                rise_at = i;
            vectors++;
            if (debug_out !== m_acc[2]) begin
                errors++;
                $display("FAIL dbg cyc %0d: got %b want %b", i, debug_out, m_acc[2]);
            end
        end
        vectors++;
        if (rise_at !== 10) begin
            errors++;
            $display("FAIL dbg_restart: got %0d want 10", rise_at);
        end
        pad_in = '0;
    endtask

    task automatic test_random();
        logic [11:0] got, exp;
        int hold[3];
        int vs_left;
        apply_reset();
        for (int b = 0; b < 3; b++)
            hold[b] = $urandom_range(1, 14);
        vs_left = $urandom_range(5, 25);
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 3; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    pad_in[b] = ~pad_in[b];
                    hold[b] = $urandom_range(1, 14);
                end
            end
            vs_left--;
            if (vs_left <= 0) begin
                vsync   = ~vsync;
                vs_left = $urandom_range(3, 25);
            end
            if ($urandom_range(0, 19) == 0)
                pad_in[11:3] = 9'($urandom);
            step();
            vectors++;
            got = {jump_out, jump_pulse, halt_out, debug_out, cfg_accel, cfg_speed};
            exp = {m_acc[0], m_pulse, m_halt, m_acc[2], m_accel, m_speed};
            if (got !== exp) begin
                errors++;
                $display("FAIL rand cyc %0d: got %h want %h", i, got, exp);
            end
        end
        pad_in = '0;
        vsync  = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        pad_in = '0;
        vsync  = 1'b0;
        model_clear();
        #1 reset = 1'b0;
        #1;
        test_reset();
        test_jump_clean();
        test_bounce();
        test_halt();
        test_cfg();
        test_reset_midcount();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
